bird_sequencer: RTL and testbench
=================================

Name: bird_sequencer

Overview:
Sequencer FSM that drives the 4-bit control code of the bird drawing/motion datapath. On each frame tick it runs one step: erase the 4x4 sprite, move it one pixel, redraw it. It selects direction from a random source and bounces off screen edges. It also runs the shot-fall and escape sequences and emits hit/escape pulses to game logic.

Parameters:
MOVE_DIV, 2, frame ticks per movement step (1..15)
DIR_HOLD, 16, movement steps between random direction changes (1..255)
ESCAPE_FRAMES, 600, frame ticks after launch before the bird escapes (1..1023)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
start  in  1  level; bird launches/flies only while high
frame_tick  in  1  one-cycle pulse per video frame
draw_done  in  1  datapath done flag; high once the 16th pixel is issued, stays high while control is CLEAR/DRAW
shot  in  1  datapath hit flag (sticky until fall completes)
flying  in  1  datapath flag; high while a fall/escape step moved the bird
bird_x  in  8  current bird X (top-left)
bird_y  in  7  current bird Y (top-left)
rand_bits  in  2  free-running random bits
control  out  4  datapath command code
hit  out  1  one-cycle pulse: shot bird reached edge
escaped  out  1  one-cycle pulse: escaping bird left screen
busy  out  1  high in any state other than HOLD

Behaviour:
- Control codes: HOLD 0000, CLEAR 0001, UP_LEFT 0010, UP_RIGHT 0011, PREHOLD 0100, DRAW 0101, DOWN_RIGHT 0110, DOWN_LEFT 0111, SHOT 1000, ESCAPE 1001, RESET 1010. control is the registered state.
- Async reset: state=RESET, dir=00, move_cnt=0, dir_cnt=0, esc_cnt=0, mode=NORMAL, hit=0, escaped=0.
- RESET: held 1 cycle, then HOLD. All counters clear; mode=NORMAL.
- HOLD: waits for frame_tick with start=1. frame_tick with start=0 is ignored and counters freeze.
- On a qualifying tick in HOLD:
  - esc_cnt increments, saturating at ESCAPE_FRAMES.
  - Priority 1: shot=1 sets mode=FALL and goes to CLEAR.
  - Priority 2: esc_cnt reached ESCAPE_FRAMES sets mode=ESC and goes to CLEAR.
  - Priority 3: move_cnt==MOVE_DIV-1 clears move_cnt and goes to CLEAR.
  - Otherwise move_cnt increments and the FSM stays in HOLD.
  - When shot and escape expiry coincide, shot wins.
- CLEAR: stay until draw_done=1, then exit on the following edge. The transition fires on the first cycle draw_done is seen.
  - mode NORMAL: go to the move state for dir.
  - mode FALL: go to SHOT.
  - mode ESC: go to ESCAPE.
- Move states (exactly 1 cycle): dir 00=UP_RIGHT, 01=UP_LEFT, 10=DOWN_RIGHT, 11=DOWN_LEFT, then DRAW.
  - Direction update happens on exit from CLEAR, in mode NORMAL, before choosing the move state.
  - dir_cnt increments; at DIR_HOLD-1, dir=rand_bits and dir_cnt=0.
  - Bounce overrides random choice, evaluated after it on the same edge:
    - bird_x==0 forces dir[0]=0 (right).
    - bird_x>=156 forces dir[0]=1 (left).
    - bird_y==0 forces dir[1]=1 (down).
    - bird_y>=116 forces dir[1]=0 (up).
- SHOT / ESCAPE: 1 cycle, then DRAW.
- DRAW: stay until draw_done=1, then PREHOLD.
- PREHOLD (1 cycle; lets draw_done deassert):
  - mode FALL, flying=0: hit=1 for this cycle's output edge, then RESET.
  - mode ESC, flying=0: escaped=1, then RESET.
  - Otherwise go to HOLD.
  - flying is sampled here, never in SHOT/ESCAPE (it is registered one cycle late).
- hit and escaped are registered one-cycle pulses; never both high together.
- busy=0 only in HOLD.
- start falling mid-sequence: the current CLEAR..PREHOLD sequence completes; the FSM then parks in HOLD.
- frame_tick outside HOLD is dropped; no queuing.
- Counter widths: move_cnt 4b, dir_cnt 8b, esc_cnt 10b.

Test Plan:
- Reset asserted mid-DRAW → control=1010 same cycle (async). After release: 1 cycle RESET then 0000; hit=escaped=0.
- start=1, MOVE_DIV=2, two ticks, draw_done pulsed after 16 cycles each phase → sequence 0000→0001→(move code)→0101→0100→0000 on the second tick only.
- bird_x=156, bird_y=50, dir=00, a move step runs → move state emitted is UP_LEFT (0010). Repeat with bird_y=0 → DOWN_LEFT (0111).
- shot=1 at tick → CLEAR→SHOT(1000)→DRAW→PREHOLD per tick while flying=1. Once flying=0 at PREHOLD → hit pulse 1 cycle, then RESET.
- ESCAPE_FRAMES=4, no shot → 5th tick enters ESCAPE path. Escaped pulse when flying=0 at PREHOLD; esc_cnt cleared after RESET.
- shot=1 on the same tick esc_cnt hits ESCAPE_FRAMES → SHOT path taken, escaped never pulses.

Source files
------------

// File: rtl/bird_if.sv
// bird_if: sequencer <-> datapath/game-logic signal bundle
interface bird_if;
  logic       start;
  logic       frame_tick;
  logic       draw_done;
  logic       shot;
  logic       flying;
  logic [7:0] bird_x;
  logic [6:0] bird_y;
  logic [1:0] rand_bits;
  logic [3:0] control;
  logic       hit;
  logic       escaped;
  logic       busy;
  modport master (output start, frame_tick, draw_done, shot, flying, bird_x, bird_y, rand_bits,
                  input control, hit, escaped, busy);
  modport slave  (input start, frame_tick, draw_done, shot, flying, bird_x, bird_y, rand_bits,
                  output control, hit, escaped, busy);
endinterface

// File: rtl/bird_sequencer.sv
// bird_sequencer: per-frame erase/move/redraw sequencer with edge bounce, shot-fall and escape paths
module bird_sequencer #(
  parameter int MOVE_DIV      = 2,
  parameter int DIR_HOLD      = 16,
  parameter int ESCAPE_FRAMES = 600
) (
  input logic   clk,
  input logic   reset_n,
  bird_if.slave bus
);
  typedef enum logic [3:0] {
    S_HOLD = 4'b0000, S_CLEAR = 4'b0001, S_UP_LEFT = 4'b0010, S_UP_RIGHT = 4'b0011,
    S_PREHOLD = 4'b0100, S_DRAW = 4'b0101, S_DOWN_RIGHT = 4'b0110, S_DOWN_LEFT = 4'b0111,
    S_SHOT = 4'b1000, S_ESCAPE = 4'b1001, S_RESET = 4'b1010
  } state_t;
  typedef enum logic [1:0] {M_NORMAL, M_FALL, M_ESC} mode_t;
  localparam logic [3:0] MOVE_LAST = 4'(MOVE_DIV - 1);
  localparam logic [7:0] DIR_LAST  = 8'(DIR_HOLD - 1);
  localparam logic [9:0] ESC_MAX   = 10'(ESCAPE_FRAMES);
  state_t     r_state, w_state;
  mode_t      r_mode, w_mode;
  logic [1:0] r_dir, w_dir;
  logic [3:0] r_move_cnt, w_move_cnt;
  logic [7:0] r_dir_cnt, w_dir_cnt;
  logic [9:0] r_esc_cnt, w_esc_cnt;
  logic       r_hit, w_hit, r_escaped, w_escaped;
  logic       w_tick, w_dir_due;
  logic [1:0] w_pick, w_bdir;
  state_t     w_move_state;
  assign w_tick    = bus.frame_tick & bus.start;
  assign w_dir_due = r_dir_cnt == DIR_LAST;
  assign w_pick    = w_dir_due ? bus.rand_bits : r_dir;
  // edge bounce overrides the random pick on the same step
  assign w_bdir[0] = (bus.bird_x == 8'd0) ? 1'b0 : (bus.bird_x >= 8'd156) ? 1'b1 : w_pick[0];
  assign w_bdir[1] = (bus.bird_y == 7'd0) ? 1'b1 : (bus.bird_y >= 7'd116) ? 1'b0 : w_pick[1];
  assign w_move_state = state_t'({1'b0, w_bdir[1], 1'b1, w_bdir[0] ~^ w_bdir[1]});
  always_comb begin
    w_state    = r_state;
    w_mode     = r_mode;
    w_dir      = r_dir;
    w_move_cnt = r_move_cnt;
    w_dir_cnt  = r_dir_cnt;
    w_esc_cnt  = r_esc_cnt;
    w_hit      = 1'b0;
    w_escaped  = 1'b0;
    case (r_state)
      S_RESET: begin
        w_state    = S_HOLD;
        w_mode     = M_NORMAL;
        w_move_cnt = 4'd0;
        w_dir_cnt  = 8'd0;
        w_esc_cnt  = 10'd0;
      end
      S_HOLD: if (w_tick) begin
        w_esc_cnt = (r_esc_cnt == ESC_MAX) ? r_esc_cnt : r_esc_cnt + 10'd1;
        if (bus.shot) begin
          w_mode  = M_FALL;
          w_state = S_CLEAR;
        end else if (r_esc_cnt == ESC_MAX) begin
          w_mode  = M_ESC;
          w_state = S_CLEAR;
        end else if (r_move_cnt == MOVE_LAST) begin
          w_move_cnt = 4'd0;
          w_state    = S_CLEAR;
        end else
          w_move_cnt = r_move_cnt + 4'd1;
      end
      S_CLEAR: if (bus.draw_done) begin
        w_state = (r_mode == M_FALL) ? S_SHOT : (r_mode == M_ESC) ? S_ESCAPE : w_move_state;
        if (r_mode == M_NORMAL) begin
          w_dir     = w_bdir;
          w_dir_cnt = w_dir_due ? 8'd0 : r_dir_cnt + 8'd1;
        end
      end
      S_UP_LEFT, S_UP_RIGHT, S_DOWN_RIGHT, S_DOWN_LEFT, S_SHOT, S_ESCAPE: w_state = S_DRAW;
      S_DRAW: w_state = bus.draw_done ? S_PREHOLD : S_DRAW;
      S_PREHOLD: begin
        w_hit     = (r_mode == M_FALL) & ~bus.flying;
        w_escaped = (r_mode == M_ESC) & ~bus.flying;
        w_state   = (w_hit | w_escaped) ? S_RESET : S_HOLD;
      end
      default: w_state = S_RESET;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state    <= S_RESET;
      r_mode     <= M_NORMAL;
      r_dir      <= 2'b00;
      r_move_cnt <= 4'd0;
      r_dir_cnt  <= 8'd0;
      r_esc_cnt  <= 10'd0;
      r_hit      <= 1'b0;
      r_escaped  <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_mode     <= w_mode;
      r_dir      <= w_dir;
      r_move_cnt <= w_move_cnt;
      r_dir_cnt  <= w_dir_cnt;
      r_esc_cnt  <= w_esc_cnt;
      r_hit      <= w_hit;
      r_escaped  <= w_escaped;
    end
  assign bus.control = r_state;
  assign bus.hit     = r_hit;
  assign bus.escaped = r_escaped;
  assign bus.busy    = r_state != S_HOLD;
endmodule

// File: tb/tb_bird_sequencer.sv
// tb_bird_sequencer: directed tests of the bird sequencer against hand-derived control code traces
module tb_bird_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [4:0] pix;
  bird_if u_if();
  bird_sequencer #(.MOVE_DIV(2), .DIR_HOLD(16), .ESCAPE_FRAMES(4)) dut (
    .clk(clk), .reset_n(reset_n), .bus(u_if.slave)
  );
  always #5 clk = ~clk;
  // datapath stand-in: draw_done rises after 16 cycles in CLEAR/DRAW, drops once control leaves them
  always @(posedge clk or negedge reset_n)
    if (!reset_n) pix <= 5'd0;
    else pix <= (u_if.control == 4'h1 || u_if.control == 4'h5) ? ((pix == 5'd16) ? pix : pix + 5'd1) : 5'd0;
  assign u_if.draw_done = pix == 5'd16;

  task automatic do_reset();
    u_if.start = 1'b0; u_if.frame_tick = 1'b0; u_if.shot = 1'b0; u_if.flying = 1'b0;
    @(negedge clk) reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_tick(input bit disturb, output logic [31:0] seq, output int hits, output int escs, output bit tmo);
    logic [3:0] last;
    seq = 32'h0; last = 4'hF; hits = 0; escs = 0; tmo = 1'b1;
    @(negedge clk) u_if.frame_tick = 1'b1;
    @(negedge clk) u_if.frame_tick = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (k > 0) @(negedge clk);
      if (disturb && k == 3) begin u_if.frame_tick = 1'b1; u_if.start = 1'b0; end
      if (disturb && k == 4) u_if.frame_tick = 1'b0;
      if (u_if.control !== last) begin seq = {seq[27:0], u_if.control}; last = u_if.control; end
      hits += int'(u_if.hit);
      escs += int'(u_if.escaped);
      if (u_if.control === 4'h0) begin tmo = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    bit tmo;
    int budget;
    logic [31:0] seq;
    int h, e;
    repeat (2) @(negedge clk);
    checks++; if (u_if.control !== 4'hA) begin failures++; $display("FAIL por_ctrl got=%h exp=a", u_if.control); end
    checks++; if ({u_if.hit, u_if.escaped, u_if.busy} !== 3'b001) begin failures++; $display("FAIL por_flags got=%b exp=001", {u_if.hit, u_if.escaped, u_if.busy}); end
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (u_if.control !== 4'h0 || u_if.busy !== 1'b0) begin failures++; $display("FAIL por_hold got=%h/%b exp=0/0", u_if.control, u_if.busy); end
    u_if.start = 1'b1;
    run_tick(1'b0, seq, h, e, tmo);
    @(negedge clk) u_if.frame_tick = 1'b1;
    @(negedge clk) u_if.frame_tick = 1'b0;
    budget = 0;
    while (u_if.control !== 4'h5 && budget < 100) begin @(negedge clk); budget++; end
    checks++; if (budget >= 100) begin failures++; $display("FAIL reach_draw got=timeout exp=draw"); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (u_if.control !== 4'hA) begin failures++; $display("FAIL async_ctrl got=%h exp=a", u_if.control); end
    checks++; if ({u_if.hit, u_if.escaped} !== 2'b00) begin failures++; $display("FAIL async_pulses got=%b exp=00", {u_if.hit, u_if.escaped}); end
    @(negedge clk) reset_n = 1'b1;
    checks++; if (u_if.control !== 4'hA) begin failures++; $display("FAIL rel_reset got=%h exp=a", u_if.control); end
    @(negedge clk);
    checks++; if (u_if.control !== 4'h0 || u_if.hit !== 1'b0 || u_if.escaped !== 1'b0) begin failures++; $display("FAIL rel_hold got=%h exp=0", u_if.control); end
  endtask

  task automatic test_move();
    logic [31:0] seq;
    int h, e;
    bit tmo;
    do_reset();
    u_if.bird_x = 8'd80; u_if.bird_y = 7'd50;
    run_tick(1'b0, seq, h, e, tmo);
    checks++; if (seq !== 32'h0) begin failures++; $display("FAIL idle_tick got=%h exp=0", seq); end
    u_if.start = 1'b1;
    run_tick(1'b0, seq, h, e, tmo);
    checks++; if (seq !== 32'h0) begin failures++; $display("FAIL first_tick got=%h exp=0", seq); end
    run_tick(1'b0, seq, h, e, tmo);
    checks++; if (seq !== 32'h00013540) begin failures++; $display("FAIL second_tick got=%h exp=00013540", seq); end
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL move_timeout got=%b exp=0", tmo); end
  endtask

  task automatic test_bounce();
    logic [7:0] xs [4] = '{8'd156, 8'd156, 8'd0, 8'd200};
    logic [6:0] ys [4] = '{7'd50, 7'd0, 7'd120, 7'd116};
    logic [3:0] mv [4] = '{4'h2, 4'h7, 4'h3, 4'h2};
    logic [31:0] seq, exp;
    int h, e;
    bit tmo;
    for (int i = 0; i < 4; i++) begin
      do_reset();
      u_if.bird_x = xs[i]; u_if.bird_y = ys[i]; u_if.start = 1'b1;
      run_tick(1'b0, seq, h, e, tmo);
      run_tick(1'b0, seq, h, e, tmo);
      exp = {12'h0, 4'h1, mv[i], 4'h5, 4'h4, 4'h0};
      checks++; if (seq !== exp) begin failures++; $display("FAIL bounce%0d got=%h exp=%h", i, seq, exp); end
    end
  endtask

  task automatic test_shot();
    logic [31:0] seq;
    int h, e;
    bit tmo;
    do_reset();
    u_if.bird_x = 8'd80; u_if.bird_y = 7'd50; u_if.start = 1'b1; u_if.shot = 1'b1; u_if.flying = 1'b1;
    run_tick(1'b0, seq, h, e, tmo);
    checks++; if (seq !== 32'h00018540 || h !== 0) begin failures++; $display("FAIL fall1 got=%h/%0d exp=00018540/0", seq, h); end
    run_tick(1'b0, seq, h, e, tmo);
    checks++; if (seq !== 32'h00018540) begin failures++; $display("FAIL fall2 got=%h exp=00018540", seq); end
    u_if.flying = 1'b0;
    run_tick(1'b0, seq, h, e, tmo);
    checks++; if (seq !== 32'h001854A0) begin failures++; $display("FAIL fall_end got=%h exp=001854a0", seq); end
    checks++; if (h !== 1 || e !== 0) begin failures++; $display("FAIL hit_pulse got=%0d/%0d exp=1/0", h, e); end
  endtask

  task automatic test_escape();
    logic [31:0] seq;
    int h, e;
    bit tmo;
    do_reset();
    u_if.bird_x = 8'd80; u_if.bird_y = 7'd50; u_if.start = 1'b1; u_if.flying = 1'b1;
    repeat (4) run_tick(1'b0, seq, h, e, tmo);
    checks++; if (seq !== 32'h00013540) begin failures++; $display("FAIL esc_pre got=%h exp=00013540", seq); end
    run_tick(1'b0, seq, h, e, tmo);
    checks++; if (seq !== 32'h00019540 || e !== 0) begin failures++; $display("FAIL esc_fly got=%h/%0d exp=00019540/0", seq, e); end
    u_if.flying = 1'b0;
    run_tick(1'b0, seq, h, e, tmo);
    checks++; if (seq !== 32'h001954A0) begin failures++; $display("FAIL esc_end got=%h exp=001954a0", seq); end
    checks++; if (e !== 1 || h !== 0) begin failures++; $display("FAIL esc_pulse got=%0d/%0d exp=1/0", e, h); end
    run_tick(1'b0, seq, h, e, tmo);
    checks++; if (seq !== 32'h0) begin failures++; $display("FAIL esc_cleared got=%h exp=0", seq); end
  endtask

  task automatic test_shot_beats_escape();
    logic [31:0] seq;
    int h, e;
    bit tmo;
    do_reset();
    u_if.bird_x = 8'd80; u_if.bird_y = 7'd50; u_if.start = 1'b1;
    repeat (4) run_tick(1'b0, seq, h, e, tmo);
    u_if.shot = 1'b1;
    run_tick(1'b0, seq, h, e, tmo);
    checks++; if (seq !== 32'h001854A0) begin failures++; $display("FAIL tie_seq got=%h exp=001854a0", seq); end
    checks++; if (h !== 1 || e !== 0) begin failures++; $display("FAIL tie_pulses got=%0d/%0d exp=1/0", h, e); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] seq;
    int h, e;
    bit tmo;
    do_reset();
    u_if.bird_x = 8'd80; u_if.bird_y = 7'd50; u_if.start = 1'b1;
    run_tick(1'b0, seq, h, e, tmo);
    run_tick(1'b1, seq, h, e, tmo);
    checks++; if (seq !== 32'h00013540) begin failures++; $display("FAIL drop_start got=%h exp=00013540", seq); end
    run_tick(1'b0, seq, h, e, tmo);
    checks++; if (seq !== 32'h0) begin failures++; $display("FAIL parked got=%h exp=0", seq); end
    u_if.start = 1'b1;
    run_tick(1'b0, seq, h, e, tmo);
    checks++; if (seq !== 32'h0) begin failures++; $display("FAIL no_queue got=%h exp=0", seq); end
    run_tick(1'b0, seq, h, e, tmo);
    checks++; if (seq !== 32'h00013540) begin failures++; $display("FAIL resume got=%h exp=00013540", seq); end
  endtask

  initial begin
    u_if.start = 1'b0; u_if.frame_tick = 1'b0; u_if.shot = 1'b0; u_if.flying = 1'b0;
    u_if.bird_x = 8'd80; u_if.bird_y = 7'd50; u_if.rand_bits = 2'b00;
    test_reset();
    test_move();
    test_bounce();
    test_shot();
    test_escape();
    test_shot_beats_escape();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
